// File: rtl/hpi_pkg.sv
// Shared widths and response-FSM state encoding for the HPI read responder.
package hpi_pkg;
  localparam int HPI_DATA_W = 64;
  localparam int HPI_ADDR_W = 64;

  typedef enum logic [1:0] {RSP_IDLE, RSP_WAIT, RSP_RESP} rsp_state_t;
endpackage

// File: rtl/hpi_rd_responder_if.sv
// Master read port between the driver (master) and the responder (slave).
// master_err exists only when HPI_RESP_OOR_EN is defined.
interface hpi_rd_responder_if;
  import hpi_pkg::*;

  logic [HPI_ADDR_W-1:0] master_addr;
  logic                  master_rd;
  logic [HPI_DATA_W-1:0] master_data_out;
  logic                  master_data_out_val;
`ifdef HPI_RESP_OOR_EN
  logic                  master_err;

  modport master (output master_addr, master_rd,
                  input  master_data_out, master_data_out_val, master_err);
  modport slave  (input  master_addr, master_rd,
                  output master_data_out, master_data_out_val, master_err);
`else
  modport master (output master_addr, master_rd,
                  input  master_data_out, master_data_out_val);
  modport slave  (input  master_addr, master_rd,
                  output master_data_out, master_data_out_val);
`endif
endinterface

// File: rtl/hpi_sync_fifo.sv
// In-order request queue; one-edge push/pop, a push into a full queue is taken only with a same-edge pop.
// Pointers carry a wrap bit so level = wr_ptr - rd_ptr covers empty through full.
module hpi_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW_F = $clog2(DEPTH);

  logic [AW_F:0]      wr_ptr_q, wr_ptr_d;
  logic [AW_F:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (level == (AW_F+1)'(DEPTH));
  assign dout    = mem_q[rd_ptr_q[AW_F-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW_F-1:0]] <= din;
  end
endmodule

// File: rtl/hpi_rd_responder.sv
// Memory-model read responder: requests are never stalled, queued in order, answered LATENCY+1 edges after pop.
// HPI_RESP_OOR_EN adds master_err and zero data for addresses >= DEPTH; otherwise the index wraps.
module hpi_rd_responder
  import hpi_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 3,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  hpi_rd_responder_if.slave      bus,
  input  logic [AW-1:0]          ld_addr,
  input  logic                   ld_wr,
  input  logic [HPI_DATA_W-1:0]  ld_data,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic [LW-1:0]          fifo_level
);
  localparam int CW = $clog2(LATENCY + 1);

  rsp_state_t              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [HPI_ADDR_W-1:0]   addr_q, addr_d;
  logic [HPI_DATA_W-1:0]   data_q, data_d;
  logic                    val_q, val_d;
  logic                    ovf_q, ovf_d;
  logic [HPI_DATA_W-1:0]   ram_q [DEPTH];

  logic                    fifo_full, fifo_empty, fifo_pop, push_drop, rd_fire;
  logic [HPI_ADDR_W-1:0]   fifo_dout;
  logic [HPI_DATA_W-1:0]   rd_data_c;

  assign push_drop = bus.master_rd && fifo_full && !fifo_pop;

  hpi_sync_fifo #(.WIDTH(HPI_ADDR_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.master_rd && !push_drop),
    .pop   (fifo_pop),
    .din   (bus.master_addr),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef HPI_RESP_OOR_EN
  logic oor_c, err_q, err_d;
  assign oor_c          = (addr_q >= HPI_ADDR_W'(DEPTH));
  assign rd_data_c      = oor_c ? '0 : ram_q[addr_q[AW-1:0]];
  assign err_d          = rd_fire && oor_c;
  assign bus.master_err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[HPI_ADDR_W-1:AW];
  assign rd_data_c      = ram_q[addr_q[AW-1:0]];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    val_d    = 1'b0;
    fifo_pop = 1'b0;
    rd_fire  = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_dout;
          cnt_d    = CW'(LATENCY - 1);
          state_d  = RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rd_fire = 1'b1;
          data_d  = rd_data_c;
          val_d   = 1'b1;
          state_d = RSP_RESP;
        end
      end
      RSP_RESP: begin
        // Back-to-back service: pop the next request on the strobe cycle.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_dout;
          cnt_d    = CW'(LATENCY - 1);
          state_d  = RSP_WAIT;
        end else begin
          state_d = RSP_IDLE;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  // A drop on the same edge as ovf_clr keeps the flag set.
  assign ovf_d = push_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RSP_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
    end
  end

  // Read-before-write: the read above samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (ld_wr) ram_q[ld_addr] <= ld_data;
  end

  assign bus.master_data_out     = data_q;
  assign bus.master_data_out_val = val_q;
  assign ovf                     = ovf_q;
endmodule

// File: tb/tb_hpi_rd_responder.sv
// Randomized and directed bench for hpi_rd_responder against a queue/timestamp reference model.
module tb_hpi_rd_responder;
  localparam int DEPTH      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LATENCY    = 3;
  localparam int AW         = $clog2(DEPTH);
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_wr = 1'b0;
  logic [63:0]   ld_data = '0;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  hpi_rd_responder_if bus();

  hpi_rd_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ld_addr    (ld_addr),
    .ld_wr      (ld_wr),
    .ld_data    (ld_data),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: each accepted request is stamped with the edge it is
  // taken into service (p); its data is read from the RAM at edge p+LATENCY.
  typedef struct {
    logic [63:0] addr;
    int          p;
  } req_t;

  req_t        pend[$];
  logic [63:0] ram_m [DEPTH];
  int          edge_n = 0;
  int          last_p = -100;
  logic        m_ovf = 1'b0;
  logic [63:0] m_data = '0;
  logic        m_val = 1'b0;
  logic        m_err = 1'b0;
  int          m_level = 0;

  task automatic step();
    int   lvl;
    bit   pop_now, drop;
    req_t r;
    @(posedge clk);
    edge_n++;
    lvl = 0;
    pop_now = 0;
    foreach (pend[i]) begin
      if (pend[i].p == edge_n) pop_now = 1;
      if (pend[i].p >= edge_n) lvl++;
    end
    m_val = 1'b0;
    m_err = 1'b0;
    if (pend.size() > 0 && pend[0].p + LATENCY == edge_n) begin
      r = pend.pop_front();
      m_val = 1'b1;
`ifdef HPI_RESP_OOR_EN
      if (r.addr >= 64'(DEPTH)) begin
        m_data = '0;
        m_err  = 1'b1;
      end else begin
        m_data = ram_m[r.addr % DEPTH];
      end
`else
      m_data = ram_m[r.addr % DEPTH];
`endif
    end
    drop = 0;
    if (bus.master_rd) begin
      if (lvl == FIFO_DEPTH && !pop_now) begin
        drop = 1;
      end else begin
        r.addr = bus.master_addr;
        r.p    = (edge_n + 1 > last_p + LATENCY + 1) ? edge_n + 1 : last_p + LATENCY + 1;
        last_p = r.p;
        pend.push_back(r);
      end
    end
    if (ld_wr) ram_m[ld_addr] = ld_data;
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_level = 0;
    foreach (pend[i]) if (pend[i].p > edge_n) m_level++;
    #1;
    chk("val", 64'(bus.master_data_out_val), 64'(m_val));
    chk("data", bus.master_data_out, m_data);
    chk("level", 64'(fifo_level), 64'(m_level));
    chk("ovf", 64'(ovf), 64'(m_ovf));
`ifdef HPI_RESP_OOR_EN
    chk("err", 64'(bus.master_err), 64'(m_err));
`endif
  endtask

  task automatic idle(input int n);
    bus.master_rd = 1'b0;
    ld_wr   = 1'b0;
    ovf_clr = 1'b0;
    repeat (n) step();
  endtask

  task automatic model_reset();
    pend.delete();
    last_p = -100;
    m_ovf  = 1'b0;
    m_data = '0;
    m_val  = 1'b0;
  endtask

  logic [63:0] got_q[$];
  logic [63:0] got;
  int          req_e, seen, peak;

  initial begin
    bus.master_rd   = 1'b0;
    bus.master_addr = '0;
    #3;
    chk("reset_val", 64'(bus.master_data_out_val), 64'd0);
    chk("reset_data", bus.master_data_out, 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Preload the whole RAM, then the fixed test words.
    for (int i = 0; i < DEPTH; i++) begin
      ld_wr = 1'b1; ld_addr = AW'(i); ld_data = {$urandom, $urandom};
      step();
    end
    ld_addr = 1; ld_data = 64'h1234_5678_9ABC_DEC0; step();
    for (int i = 0; i < 4; i++) begin
      ld_addr = AW'(i); ld_data = 64'hA0 + 64'(i); step();
    end
    ld_addr = 1; ld_data = 64'h1234_5678_9ABC_DEC0; step();
    idle(2);

    // Lone request latency.
    bus.master_rd = 1'b1; bus.master_addr = 64'd1;
    step();
    req_e = edge_n;
    bus.master_rd = 1'b0;
    seen = -1;
    got  = '0;
    for (int i = 0; i < 12 && seen < 0; i++) begin
      step();
      if (bus.master_data_out_val) begin
        seen = edge_n;
        got  = bus.master_data_out;
      end
    end
    chk("lat_edges", 64'(seen - req_e), 64'(LATENCY + 1));
    chk("lat_data", got, 64'h1234_5678_9ABC_DEC0);
    idle(4);

    // Restore RAM[1] to A1, then four back-to-back reads of 0..3.
    ld_wr = 1'b1; ld_addr = 1; ld_data = 64'hA1; step(); ld_wr = 1'b0;
    peak = 0;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.master_rd = 1'b1; bus.master_addr = 64'(i);
      step();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (bus.master_data_out_val) got_q.push_back(bus.master_data_out);
    end
    bus.master_rd = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (bus.master_data_out_val) got_q.push_back(bus.master_data_out);
    end
    chk("burst_peak", 64'(peak), 64'd3);
    chk("burst_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("burst_order", got_q[i], 64'hA0 + 64'(i));

    // Long burst overflows the queue; then clear the sticky flag.
    for (int i = 0; i < 8; i++) begin
      bus.master_rd = 1'b1; bus.master_addr = 64'(i % 4);
      step();
    end
    bus.master_rd = 1'b0;
    step();
    chk("ovf_set", 64'(ovf), 64'd1);
    idle(40);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf), 64'd0);
    idle(2);

    // Read-before-write on the RAM read edge.
    bus.master_rd = 1'b1; bus.master_addr = 64'd2; step();
    bus.master_rd = 1'b0;
    repeat (LATENCY) step();
    ld_wr = 1'b1; ld_addr = 2; ld_data = 64'hBEEF;
    step();
    ld_wr = 1'b0;
    chk("rbw_val", 64'(bus.master_data_out_val), 64'd1);
    chk("rbw_old", bus.master_data_out, 64'hA2);
    idle(2);
    bus.master_rd = 1'b1; bus.master_addr = 64'd2; step();
    bus.master_rd = 1'b0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.master_data_out_val) got = bus.master_data_out;
    end
    chk("rbw_new", got, 64'hBEEF);

    // Reset while WAITing with two requests queued.
    for (int i = 0; i < 3; i++) begin
      bus.master_rd = 1'b1; bus.master_addr = 64'(i); step();
    end
    bus.master_rd = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_val", 64'(bus.master_data_out_val), 64'd0);
    chk("rst_data", bus.master_data_out, 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.master_data_out_val) got_q.push_back(bus.master_data_out);
    end
    chk("rst_no_resp", 64'(got_q.size()), 64'd0);
    chk("rst_level_after", 64'(fifo_level), 64'd0);

    // Address beyond DEPTH.
    bus.master_rd = 1'b1; bus.master_addr = 64'h10; step();
    bus.master_rd = 1'b0;
    got = 64'hDEAD;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.master_data_out_val) got = bus.master_data_out;
    end
`ifdef HPI_RESP_OOR_EN
    chk("oor_data", got, 64'd0);
`else
    chk("oor_wrap", got, ram_m[0]);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.master_rd = ($urandom_range(0, 9) < 6);
      bus.master_addr = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                                    : 64'($urandom_range(0, DEPTH - 1));
      ld_wr   = ($urandom_range(0, 9) < 3);
      ld_addr = AW'($urandom_range(0, DEPTH - 1));
      ld_data = {$urandom, $urandom};
      ovf_clr = ($urandom_range(0, 9) == 0);
      step();
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
